// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic light and its pedestrian button.
// Light encodings, FSM state type and timer width.
package semaforo_pkg;

    localparam logic [2:0] VERDE    = 3'b001;
    localparam logic [2:0] AMARELO  = 3'b010;
    localparam logic [2:0] VERMELHO = 3'b100;

    localparam int TW = 8;

    typedef logic [1:0] estado_t;

    localparam estado_t OCIOSO   = 2'd0;
    localparam estado_t PEDIDO   = 2'd1;
    localparam estado_t BLOQUEIO = 2'd2;

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchronizer plus debouncer for the raw push-button.
// rise pulses combinationally on the edge the debounced level goes 0->1.
module debounce_botao
    import semaforo_pkg::*;
#(
    parameter logic [TW-1:0] DEBOUNCE = 8'd4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic          s1_q;
    logic          s2_q;
    logic          deb_q;
    logic          deb_d;
    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Any return of s2 to the held level restarts qualification
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == DEBOUNCE - 8'd1) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = deb_q;
    assign rise = deb_d & ~deb_q;

endmodule

// File: rtl/condicionador_botao.sv
// Pedestrian request conditioner: debounced press -> held request,
// cleared when semaforo A goes yellow, followed by a lockout window.
module condicionador_botao
    import semaforo_pkg::*;
#(
    parameter logic [TW-1:0] DEBOUNCE = 8'd4,
    parameter logic [TW-1:0] LOCKOUT  = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_in,
    input  logic [2:0] A,
    output logic       bt,
    output logic       bloqueado
);

    logic          press;
    logic          deb_unused;
    estado_t       est_q;
    estado_t       est_d;
    logic [TW-1:0] lc_q;
    logic [TW-1:0] lc_d;
    logic          bt_q;
    logic          blq_q;

    debounce_botao #(
        .DEBOUNCE (DEBOUNCE)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (bt_in),
        .dout (deb_unused),
        .rise (press)
    );

    // Presses outside OCIOSO are merged or discarded, never queued
    always_comb begin
        est_d = est_q;
        lc_d  = lc_q;
        unique case (est_q)
            OCIOSO: begin
                if (press) begin
                    est_d = PEDIDO;
                end
            end
            PEDIDO: begin
                if (A == AMARELO) begin
                    est_d = BLOQUEIO;
                    lc_d  = LOCKOUT;
                end
            end
            BLOQUEIO: begin
                if (lc_q == '0) begin
                    est_d = OCIOSO;
                end else begin
                    lc_d = lc_q - 8'd1;
                end
            end
            default: begin
                est_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            est_q <= OCIOSO;
            lc_q  <= '0;
            bt_q  <= 1'b0;
            blq_q <= 1'b0;
        end else begin
            est_q <= est_d;
            lc_q  <= lc_d;
            bt_q  <= (est_d == PEDIDO);
            blq_q <= (est_d == BLOQUEIO);
        end
    end

    assign bt        = bt_q;
    assign bloqueado = blq_q;

endmodule

// File: tb/tb_condicionador_botao.sv
// Bench for condicionador_botao: behavioural model compared every cycle,
// plus literal edge-number expectations for the key scenarios.
module tb_condicionador_botao;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bt_in = 1'b0;
    logic [2:0] A = 3'b001;
    logic       bt;
    logic       bloqueado;

    int checks = 0;
    int errors = 0;

    condicionador_botao dut (
        .clk       (clk),
        .rst       (rst),
        .bt_in     (bt_in),
        .A         (A),
        .bt        (bt),
        .bloqueado (bloqueado)
    );

    always #5 clk = ~clk;

    localparam int DEB = 4;
    localparam int LCK = 10;

    // Edge count since last reset; first non-reset edge is 1
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Behavioural model: raw input seen two edges late; a level change
    // is accepted after DEB consecutive disagreeing edges.
    bit p1 = 0, p2 = 0, m_deb = 0;
    int run = 0;
    int mode = 0;   // 0 idle, 1 request, 2 locked
    int left = 0;   // cycles of lock still to spend
    bit exp_bt = 0, exp_blk = 0;
    bit cmp_on = 0;

    always @(posedge clk) begin
        bit press;
        press = 0;
        if (rst) begin
            p1 = 0; p2 = 0; m_deb = 0; run = 0;
            mode = 0; left = 0;
        end else begin
            if (p2 != m_deb) begin
                run = run + 1;
                if (run == DEB) begin
                    m_deb = p2;
                    run = 0;
                    press = m_deb;
                end
            end else begin
                run = 0;
            end
            p2 = p1;
            p1 = bt_in;
            case (mode)
                0: if (press) mode = 1;
                1: if (A == 3'b010) begin
                    mode = 2;
                    left = LCK + 1;
                end
                default: begin
                    left = left - 1;
                    if (left == 0) mode = 0;
                end
            endcase
        end
        exp_bt  = (mode == 1);
        exp_blk = (mode == 2);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            checks = checks + 1;
            if (bt !== exp_bt || bloqueado !== exp_blk) begin
                errors = errors + 1;
                $display("FAIL cycle-compare cyc=%0d: got bt=%b blq=%b, want bt=%b blq=%b",
                         cyc, bt, bloqueado, exp_bt, exp_blk);
            end
        end
    end

    // Edge-number bookkeeping of DUT output transitions
    int rises = 0;
    int rise_cyc = -1;
    int brise_cyc = -1;
    int bfall_cyc = -1;
    bit last_bt = 0, last_blk = 0;
    always @(negedge clk) begin
        if (bt && !last_bt) begin
            rises = rises + 1;
            rise_cyc = cyc;
        end
        if (bloqueado && !last_blk) brise_cyc = cyc;
        if (!bloqueado && last_blk) bfall_cyc = cyc;
        last_bt  = bt;
        last_blk = bloqueado;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        int r0, n, m, s;
        // Reset state
        rst = 1; bt_in = 0; A = 3'b001;
        tick(3);
        cmp_on = 1;
        chk("reset_bt", int'(bt), 0);
        chk("reset_blq", int'(bloqueado), 0);
        rst = 0;

        // Glitch of 3 cycles must not register
        tick(4);
        r0 = rises;
        bt_in = 1; tick(3);
        bt_in = 0; tick(15);
        chk("glitch_rises", rises - r0, 0);

        // Clean press held across reset release
        rst = 1; bt_in = 1; tick(2);
        rst = 0;
        r0 = rises;
        tick(10);
        chk("clean_rise_edge", rise_cyc, 6);
        chk("clean_rises", rises - r0, 1);

        // Non-yellow A values leave the request standing
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            A = (v == 3'b010) ? 3'b111 : v;
            tick(3);
        end
        A = 3'b001;
        tick(10);
        chk("held_bt", int'(bt), 1);

        // Service, and a press during lockout that must be dropped
        bt_in = 0; tick(8);
        n = cyc + 1;
        r0 = rises;
        A = 3'b010; tick(1);
        A = 3'b001;
        bt_in = 1; tick(14);
        chk("service_blq_rise", brise_cyc, n);
        chk("service_blq_fall", bfall_cyc, n + 11);
        chk("lockout_discard", rises - r0, 0);
        chk("lockout_bt", int'(bt), 0);

        // Press after lockout is accepted with normal latency
        bt_in = 0; tick(8);
        m = cyc + 1;
        bt_in = 1; tick(8);
        chk("post_lock_rise", rise_cyc, m + 5);

        A = 3'b010; tick(1);
        A = 3'b001; bt_in = 0; tick(14);

        // Bouncing input then steady high -> one request
        r0 = rises;
        for (int i = 0; i < 20; i++) begin
            bt_in = (i % 2 == 0);
            tick(1);
        end
        s = cyc + 1;
        bt_in = 1; tick(12);
        chk("bounce_rises", rises - r0, 1);
        chk("bounce_rise_edge", rise_cyc, s + 5);

        // Reset in PEDIDO drops request; re-asserts after latency
        tick(2);
        rst = 1; tick(1);
        chk("midreset_bt", int'(bt), 0);
        chk("midreset_blq", int'(bloqueado), 0);
        rst = 0; tick(10);
        chk("midreset_rerise", rise_cyc, 6);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
